// File: rtl/fetch_unit_if.sv
// fetch_unit_if -- bus bundle between the fetch unit, instruction memory and decode.
//
// Signals:
//   mem_req / mem_addr     fetch -> memory   read request and word address
//   mem_ready / mem_rdata  memory -> fetch   completion strobe and read data
//   instr / instr_pc       fetch -> decode   fetched word and its address
//   instr_valid            fetch -> decode   instr/instr_pc hold a word
//   out_ready              decode -> fetch   decode takes the word when valid & ready
//
// Modports: master = fetch unit side, slave = memory/decode side.
interface fetch_unit_if;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic        mem_ready;
    logic [31:0] mem_rdata;
    logic [31:0] instr;
    logic [31:0] instr_pc;
    logic        instr_valid;
    logic        out_ready;

    modport master (
        output mem_req, mem_addr, instr, instr_pc, instr_valid,
        input  mem_ready, mem_rdata, out_ready
    );

    modport slave (
        input  mem_req, mem_addr, instr, instr_pc, instr_valid,
        output mem_ready, mem_rdata, out_ready
    );
endinterface

// File: rtl/fetch_unit.sv
// fetch_unit -- instruction fetch sequencer between a program counter, an
// instruction memory and the decode stage.
//
// Ports:
//   clk                  sole clock, rising edge
//   reset                asynchronous active-low reset
//   run                  1 = fetching permitted, 0 = stop after current transaction
//   pc                   current program counter (upstream counter output)
//   pc_enable            one-cycle increment strobe, asserted on memory completion
//   pc_cnt_up            counter direction, constant 1
//   pc_load/pc_load_data counter load strobe and value (driven by redirect)
//   redirect/redirect_pc branch redirect strobe and target
//   fetch_err            sticky memory-timeout flag
//   bus                  fetch_unit_if.master: memory request/response and decode output
//
// Parameter:
//   TIMEOUT_CYCLES       FETCH cycles without mem_ready before abort (1..255)
//
// Build option:
//   FETCH_TIMEOUT_EN     when defined, a FETCH that waits TIMEOUT_CYCLES cycles
//                        aborts, sets fetch_err and parks in IDLE until a redirect
//                        or reset. When undefined, fetch_err is tied 0 and FETCH
//                        waits indefinitely.
module fetch_unit #(
    parameter int unsigned TIMEOUT_CYCLES = 16
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         run,
    input  logic [31:0]  pc,
    output logic         pc_enable,
    output logic         pc_cnt_up,
    output logic         pc_load,
    output logic [31:0]  pc_load_data,
    input  logic         redirect,
    input  logic [31:0]  redirect_pc,
    output logic         fetch_err,
    fetch_unit_if.master bus
);

    if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 255) begin : g_bad_timeout
        $error("fetch_unit: TIMEOUT_CYCLES must be in 1..255");
    end

    typedef enum logic [1:0] {
        IDLE,
        FETCH,
        HOLD
    } state_t;

    state_t      state;
    state_t      state_next;
    logic        armed;        // set by the first edge after reset release
    logic        capture;      // memory completion accepted this cycle
    logic        timeout_hit;  // wait limit reached in the current FETCH cycle
    logic [31:0] instr_q;
    logic [31:0] instr_pc_q;
    logic        instr_valid_q;

    // Next-state logic. Redirect overrides every other transition. The
    // 'armed' gate keeps the first edge after reset release from launching a
    // fetch, so the earliest mem_req follows the second edge.
    always_comb begin
        state_next = state;
        capture    = 1'b0;
        case (state)
            IDLE: begin
                if (run && armed && !fetch_err) state_next = FETCH;
            end
            FETCH: begin
                if (bus.mem_ready) begin
                    capture    = 1'b1;
                    state_next = HOLD;
                end else if (timeout_hit) begin
                    state_next = IDLE;
                end
            end
            HOLD: begin
                if (bus.out_ready) state_next = (run && armed) ? FETCH : IDLE;
            end
            default: state_next = IDLE;
        endcase
        if (redirect) begin
            capture    = 1'b0;
            state_next = (run && armed) ? FETCH : IDLE;
        end
    end

    // Reset forces state to IDLE asynchronously, so mem_req and pc_enable
    // drop with it; pc_load needs the explicit reset gate.
    assign bus.mem_req     = (state == FETCH) && !redirect;
    assign bus.mem_addr    = bus.mem_req ? pc : '0;
    assign pc_enable       = capture;
    assign pc_cnt_up       = 1'b1;
    assign pc_load         = redirect && reset;
    assign pc_load_data    = pc_load ? redirect_pc : '0;
    assign bus.instr       = instr_q;
    assign bus.instr_pc    = instr_pc_q;
    assign bus.instr_valid = instr_valid_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state         <= IDLE;
            armed         <= 1'b0;
            instr_q       <= '0;
            instr_pc_q    <= '0;
            instr_valid_q <= 1'b0;
        end else begin
            state <= state_next;
            armed <= 1'b1;
            if (redirect) begin
                instr_valid_q <= 1'b0;
            end else if (capture) begin
                instr_q       <= bus.mem_rdata;
                instr_pc_q    <= pc;
                instr_valid_q <= 1'b1;
            end else if (state == HOLD && bus.out_ready) begin
                instr_valid_q <= 1'b0;
            end
        end
    end

`ifdef FETCH_TIMEOUT_EN
    localparam logic [7:0] WAIT_LIMIT = 8'(TIMEOUT_CYCLES - 1);

    logic [7:0] wait_cnt;  // FETCH cycles already spent without mem_ready
    logic       err_q;

    assign timeout_hit = (wait_cnt >= WAIT_LIMIT);
    assign fetch_err   = err_q;

    // The counter restarts whenever FETCH is (re)entered, including a
    // redirect that lands back in FETCH.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wait_cnt <= '0;
            err_q    <= 1'b0;
        end else begin
            if (redirect) begin
                err_q <= 1'b0;
            end else if (state == FETCH && !bus.mem_ready && timeout_hit) begin
                err_q <= 1'b1;
            end
            if (state == FETCH && state_next == FETCH && !redirect) begin
                wait_cnt <= (wait_cnt == '1) ? wait_cnt : wait_cnt + 8'd1;
            end else begin
                wait_cnt <= '0;
            end
        end
    end
`else
    assign timeout_hit = 1'b0;
    assign fetch_err   = 1'b0;
`endif

endmodule
